// File: rtl/alu_iter_sequencer.sv
// Multi-cycle EX-stage sequencer for MUL, MULHU, DIVU and REMU.
// It uses a WIDTH-step shift-add multiplier or a restoring divider, and stalls the pipeline while it runs.
module alu_iter_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] prod, prod_next;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem, rem_next, shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quo, quo_next;
    logic [WIDTH-1:0]   result_next;
    logic               accept, last_step, neg;

    assign accept    = ((state == IDLE) || (state == DONE)) && start && !flush;
    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
        stall = accept || (state == RUN);
        busy  = (state == RUN);
        done  = (state == DONE);
    end

    // One datapath step: the multiply carry lands at the product MSB; the divide trial subtraction uses one spare sign bit.
    always_comb begin
        add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        prod_next = {add_sum, prod[WIDTH-1:1]};
        shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff      = {1'b0, shifted} - {2'b00, b_q};
        neg       = diff[WIDTH+1];
        rem_next  = neg ? shifted : diff[WIDTH:0];
        quo_next  = {quo[WIDTH-2:0], ~neg};
        case (op_q)
            2'b00:   result_next = prod_next[WIDTH-1:0];
            2'b01:   result_next = prod_next[2*WIDTH-1:WIDTH];
            2'b10:   result_next = quo_next;
            default: result_next = rem_next[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
        end else if (accept) begin
            count <= '0;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            prod  <= {{WIDTH{1'b0}}, b};
            rem   <= '0;
            quo   <= a;
        end else if ((state == RUN) && !flush) begin
            count <= count + CW'(1);
            if (op_q[1]) begin
                rem <= rem_next;
                quo <= quo_next;
            end else begin
                prod <= prod_next;
            end
            // The result register changes only when an operation completes, so a flush leaves it intact.
            if (last_step) result <= result_next;
        end
    end

endmodule

// File: doc/alu_iter_sequencer.md
# alu_iter_sequencer

Multi-cycle sequencer for the EX stage of the pipelined RISC-V core. It handles the RV32M subset that the single-cycle ALU cannot: MUL, MULHU, DIVU and REMU. It runs a WIDTH-step shift-add multiplier or a restoring divider. While an operation is in flight it stalls the pipeline, then presents the result for exactly one cycle.

## Interface
- WIDTH, default 32, operand and result width.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request from EX: begin the operation on a/b/op.
- op  in  2  operation select: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- a  in  WIDTH  operand A (multiplicand or dividend).
- b  in  WIDTH  operand B (multiplier or divisor).
- flush  in  1  abort request from the branch/flush logic.
- stall  out  1  holds IF/ID/EX pipeline registers.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse; result is valid this cycle.
- result  out  WIDTH  operation result, held until the next accepted start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 with flush=0 latches op, a and b, clears the step counter, and moves to RUN.
- RUN: performs one iteration per cycle. The step counter runs from 0 to WIDTH-1. After the step where the counter equals WIDTH-1, the FSM moves to DONE.
- DONE: done=1 and result is driven from the finished registers. On the next edge:
  - start=1 is accepted exactly as in IDLE (back-to-back operation);
  - otherwise the FSM returns to IDLE.
- start while in RUN is ignored.
- MUL/MULHU, shift-add:
  - 2*WIDTH product register initialised to {0, b};
  - each step, if product[0]=1 then a is added into the upper WIDTH+1 bits;
  - the result is then shifted right by 1 (carry enters at the MSB).
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- DIVU/REMU, restoring division:
  - WIDTH+1-bit remainder register initialised to 0; quotient register initialised to a;
  - each step, shift {rem, quo} left by 1 and trial-subtract b from rem;
  - if the result is non-negative, keep it and set quo[0]=1; otherwise restore and set quo[0]=0.
  - DIVU returns quo; REMU returns rem[WIDTH-1:0].
- Divide by zero: still takes the full latency. DIVU returns all ones; REMU returns a. No exception is raised.
- All arithmetic is unsigned modulo 2^WIDTH. No overflow flag.
- flush=1 in any state: FSM goes to IDLE on the next edge, no done pulse, result keeps its previous value. flush has priority over start.
- Reset:
  - state=IDLE, counter=0, result=0, stall=0, busy=0, done=0.
  - Reset asserted mid-operation discards the operation; no done follows.

## Timing
- Latency: start accepted at edge 0; RUN covers WIDTH cycles; done=1 in the cycle after edge WIDTH. With WIDTH=32, done is high during cycle 33 (start is cycle 0).
- stall is combinational: stall = (state==IDLE & start & !flush) | (state==DONE & start & !flush) | (state==RUN).
- stall is low in a DONE cycle without a new start, so EX consumes result and the pipeline advances in that same cycle.
- busy = (state==RUN), registered-state decode.
- done = (state==DONE), registered-state decode; it is exactly one cycle wide unless a back-to-back start follows, in which case it is still one cycle per operation.
- Operands are latched only at acceptance. Changes on a, b or op during RUN have no effect.
- Throughput: one operation per WIDTH+1 cycles.

## Test plan
- MUL a=7, b=6, WIDTH=32 -> stall high cycles 0-32, done pulse at cycle 33, result=42, then IDLE with stall=0.
- MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE; rerun with op=MUL on the same operands -> result=0x00000001.
- DIVU a=100, b=7 -> result=14; REMU with the same operands -> result=2. Issue REMU as a back-to-back start in the DIVU done cycle; its done must follow exactly 33 cycles later.
- Divide by zero: DIVU a=0x1234, b=0 -> result=0xFFFFFFFF; REMU with the same operands -> result=0x1234; both at full latency.
- flush at RUN step 10 -> IDLE next cycle, stall=0, no done, result unchanged. flush and start in the same IDLE cycle -> not accepted, stall=0.
- reset_n pulsed low mid-RUN (asynchronous, between edges) -> outputs immediately 0 and state IDLE. Toggling a, b and op during RUN -> no effect on result.
